// File: rtl/memory_game_ctl_if.sv
// Bundle between the memory-game controller, the click checkers, the colour store
// and the draw modules. The slave modport is the controller's view.
interface memory_game_ctl_if #(
    parameter int unsigned NUM_PAIRS = 8,
    parameter int unsigned AW        = 5,
    parameter int unsigned IDW       = 4,
    parameter int unsigned MOVE_W    = 8
);
    logic                   start_pressed;
    logic                   card_pressed;
    logic [AW-1:0]          card_addr;
    logic                   shuffle_req;
    logic                   shuffle_done;
    logic [AW-1:0]          id_addr;
    logic [IDW-1:0]         id_data;
    logic [4*NUM_PAIRS-1:0] card_state;
    logic                   start_screen_en;
    logic                   wait_click_en;
    logic                   end_screen_en;
    logic [MOVE_W-1:0]      move_count;
    logic [AW-1:0]          pairs_left;

    modport master (
        output start_pressed, card_pressed, card_addr, shuffle_done, id_data,
        input  shuffle_req, id_addr, card_state, start_screen_en, wait_click_en,
               end_screen_en, move_count, pairs_left
    );

    modport slave (
        input  start_pressed, card_pressed, card_addr, shuffle_done, id_data,
        output shuffle_req, id_addr, card_state, start_screen_en, wait_click_en,
               end_screen_en, move_count, pairs_left
    );
endinterface

// File: rtl/memory_game_ctl.sv
// Game-flow controller for the memory game: card reveal state, pick sequencing,
// match evaluation, timed hide-back, move counting and end-of-game detection.
module memory_game_ctl #(
    parameter int unsigned NUM_PAIRS   = 8,
    parameter int unsigned AW          = 5,
    parameter int unsigned IDW         = 4,
    parameter int unsigned HOLD_CYCLES = 65000000,
    parameter int unsigned MOVE_W      = 8
) (
    input logic              clk,
    input logic              rst_n,
    memory_game_ctl_if.slave bus
);
    localparam int unsigned NUM_CARDS = 2 * NUM_PAIRS;
    localparam int unsigned CW        = 2 * NUM_CARDS;
    localparam int unsigned TW        = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [TW-1:0]     HoldLoad  = TW'(HOLD_CYCLES - 1);
    localparam logic [MOVE_W-1:0] MoveMax   = '1;
    localparam logic [AW-1:0]     PairsInit = AW'(NUM_PAIRS);

    localparam logic [3:0] StIdle       = 4'd0;
    localparam logic [3:0] StShuffle    = 4'd1;
    localparam logic [3:0] StWaitFirst  = 4'd2;
    localparam logic [3:0] StReadFirst  = 4'd3;
    localparam logic [3:0] StWaitSecond = 4'd4;
    localparam logic [3:0] StReadSecond = 4'd5;
    localparam logic [3:0] StCompare    = 4'd6;
    localparam logic [3:0] StHold       = 4'd7;
    localparam logic [3:0] StEnd        = 4'd8;

    logic [3:0]        state_q, state_d;
    logic [CW-1:0]     cards_q, cards_d;
    logic [AW-1:0]     first_q, first_d;
    logic [AW-1:0]     second_q, second_d;
    logic [IDW-1:0]    id_first_q, id_first_d;
    logic [IDW-1:0]    id_second_q, id_second_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [MOVE_W-1:0] moves_q, moves_d;
    logic [AW-1:0]     pairs_q, pairs_d;
    logic              shuffle_req_q, shuffle_req_d;
    logic [AW-1:0]     id_addr_q, id_addr_d;
    logic              start_scr_q, wait_clk_q, end_scr_q;
    logic              click_ok;

    function automatic logic [CW-1:0] put_card(input logic [CW-1:0] v, input logic [AW-1:0] a,
                                               input logic [1:0] s);
        logic [CW-1:0] r;
        r = v;
        for (int i = 0; i < NUM_CARDS; i++) begin
            if (a == AW'(i)) r[2*i +: 2] = s;
        end
        return r;
    endfunction

    // Out-of-range addresses never match a card index, so they are rejected here.
    always_comb begin
        click_ok = 1'b0;
        for (int i = 0; i < NUM_CARDS; i++) begin
            if (bus.card_addr == AW'(i) && cards_q[2*i +: 2] == 2'b00) begin
                click_ok = bus.card_pressed;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        cards_d       = cards_q;
        first_d       = first_q;
        second_d      = second_q;
        id_first_d    = id_first_q;
        id_second_d   = id_second_q;
        timer_d       = timer_q;
        moves_d       = moves_q;
        pairs_d       = pairs_q;
        shuffle_req_d = shuffle_req_q;
        id_addr_d     = id_addr_q;
        case (state_q)
            StIdle, StEnd: begin
                if (bus.start_pressed) begin
                    state_d       = StShuffle;
                    shuffle_req_d = 1'b1;
                    cards_d       = '0;
                    moves_d       = '0;
                    pairs_d       = PairsInit;
                end
            end
            StShuffle: begin
                if (bus.shuffle_done) begin
                    state_d       = StWaitFirst;
                    shuffle_req_d = 1'b0;
                end
            end
            StWaitFirst: begin
                if (click_ok) begin
                    first_d   = bus.card_addr;
                    id_addr_d = bus.card_addr;
                    cards_d   = put_card(cards_q, bus.card_addr, 2'b01);
                    state_d   = StReadFirst;
                end
            end
            StReadFirst: begin
                id_first_d = bus.id_data;
                state_d    = StWaitSecond;
            end
            StWaitSecond: begin
                if (click_ok) begin
                    second_d  = bus.card_addr;
                    id_addr_d = bus.card_addr;
                    cards_d   = put_card(cards_q, bus.card_addr, 2'b01);
                    state_d   = StReadSecond;
                end
            end
            StReadSecond: begin
                id_second_d = bus.id_data;
                moves_d     = (moves_q == MoveMax) ? moves_q : moves_q + MOVE_W'(1);
                state_d     = StCompare;
            end
            StCompare: begin
                if (id_first_q == id_second_q) begin
                    cards_d = put_card(put_card(cards_q, first_q, 2'b10), second_q, 2'b10);
                    pairs_d = pairs_q - AW'(1);
                    state_d = (pairs_q == AW'(1)) ? StEnd : StWaitFirst;
                end else begin
                    timer_d = HoldLoad;
                    state_d = StHold;
                end
            end
            StHold: begin
                if (timer_q == '0) begin
                    cards_d = put_card(put_card(cards_q, first_q, 2'b00), second_q, 2'b00);
                    state_d = StWaitFirst;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            cards_q       <= '0;
            first_q       <= '0;
            second_q      <= '0;
            id_first_q    <= '0;
            id_second_q   <= '0;
            timer_q       <= '0;
            moves_q       <= '0;
            pairs_q       <= PairsInit;
            shuffle_req_q <= 1'b0;
            id_addr_q     <= '0;
            start_scr_q   <= 1'b1;
            wait_clk_q    <= 1'b0;
            end_scr_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cards_q       <= cards_d;
            first_q       <= first_d;
            second_q      <= second_d;
            id_first_q    <= id_first_d;
            id_second_q   <= id_second_d;
            timer_q       <= timer_d;
            moves_q       <= moves_d;
            pairs_q       <= pairs_d;
            shuffle_req_q <= shuffle_req_d;
            id_addr_q     <= id_addr_d;
            start_scr_q   <= (state_d == StIdle);
            wait_clk_q    <= (state_d == StWaitFirst) || (state_d == StWaitSecond);
            end_scr_q     <= (state_d == StEnd);
        end
    end

    assign bus.shuffle_req     = shuffle_req_q;
    assign bus.id_addr         = id_addr_q;
    assign bus.card_state      = cards_q;
    assign bus.start_screen_en = start_scr_q;
    assign bus.wait_click_en   = wait_clk_q;
    assign bus.end_screen_en   = end_scr_q;
    assign bus.move_count      = moves_q;
    assign bus.pairs_left      = pairs_q;
endmodule
